// File: rtl/mem_fill.sv
// mem_fill: sequential memory loader.
//
// A rising edge on start_fill starts a fill. The block then accepts WIDTH-bit
// words over a valid/ready handshake and writes them to addresses
// 0 .. 2^ADDR_W-1 in order, one registered write per accepted word.
// fill_done is high whenever the block is idle and no write is on the bus.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   start_fill     level request; its rising edge starts a fill
//   abort          synchronous abort of an in-progress fill
//   in_data        incoming word
//   in_valid       in_data valid
//   in_ready       block can accept a word this cycle
//   mem_address    write address (registered)
//   mem_data       write data (registered)
//   mem_wren       write enable, one-cycle pulse per word (registered)
//   fill_done      idle and no write pending
//   words_written  words written in the current/last fill (0 .. 2^ADDR_W)
//   checksum       XOR of all words written in the current/last fill
//                  (present only when MEM_FILL_CHECKSUM_EN is defined)
//
// Optional build macro: MEM_FILL_CHECKSUM_EN adds the checksum output.
//
// state | meaning
// IDLE  | waiting for a start edge; in_ready low
// LOAD  | accepting words; in_ready high
// DRAIN | final word's write is on the bus; in_ready low

module mem_fill #(
   parameter int ADDR_W = 5,
   parameter int WIDTH  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_fill,
   input  logic              abort,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [WIDTH-1:0]  mem_data,
   output logic              mem_wren,
   output logic              fill_done,
   output logic [ADDR_W:0]   words_written
`ifdef MEM_FILL_CHECKSUM_EN
   ,
   output logic [WIDTH-1:0]  checksum
`endif
);

   localparam int             DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state;
   logic            start_fill_d;
   logic [ADDR_W:0] count;
   logic            start_pulse;
   logic            start_go;
   logic            accept;

   assign start_pulse = start_fill & ~start_fill_d;
   // abort has priority over a start edge arriving in the same cycle
   assign start_go    = (state == IDLE) & start_pulse & ~abort;
   assign in_ready    = (state == LOAD);
   // a word offered in the abort cycle is dropped, not written
   assign accept      = in_valid & in_ready & ~abort;
   assign fill_done   = (state == IDLE) & ~mem_wren;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         start_fill_d  <= 1'b0;
         count         <= '0;
         mem_address   <= '0;
         mem_data      <= '0;
         mem_wren      <= 1'b0;
         words_written <= '0;
      end else begin
         start_fill_d <= start_fill;
         mem_wren     <= 1'b0;
         case (state)
            IDLE: begin
               if (start_go) begin
                  state         <= LOAD;
                  count         <= '0;
                  words_written <= '0;
               end
            end
            LOAD: begin
               if (abort) begin
                  state <= IDLE;
               end else if (accept) begin
                  mem_address   <= count[ADDR_W-1:0];
                  mem_data      <= in_data;
                  mem_wren      <= 1'b1;
                  count         <= count + ONE;
                  words_written <= count + ONE;
                  if (count == LAST_IDX) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_FILL_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum <= '0;
      end else if (start_go) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= checksum ^ in_data;
      end
   end
`endif

endmodule
